// File: rtl/seg_display_multi_if.sv
// Request/result bundle between the value source and the multi-digit segment driver.
// The source drives value/mode/bounds; the driver returns ready, glyphs and status flags.
interface seg_display_multi_if #(
   parameter int NUM_DIGITS = 2,
   parameter int DATA_W     = 8
);
   logic [DATA_W-1:0]       value;
   logic                    value_valid;
   logic                    ready;
   logic                    mode_dec;
   logic [DATA_W-1:0]       warn_lo;
   logic [DATA_W-1:0]       warn_hi;
   logic [9*NUM_DIGITS-1:0] seg;
   logic                    warn;
   logic                    overflow;
   logic                    update;

   modport master (
      output value, value_valid, mode_dec, warn_lo, warn_hi,
      input  ready, seg, warn, overflow, update
   );

   modport slave (
      input  value, value_valid, mode_dec, warn_lo, warn_hi,
      output ready, seg, warn, overflow, update
   );
endinterface

// File: rtl/seg_display_multi.sv
// Converts an unsigned value to NUM_DIGITS 9-segment glyphs in hex or decimal (sequential
// double-dabble), with leading-zero blanking, overflow dashes and a blinking range warning.
module seg_display_multi #(
   parameter int NUM_DIGITS = 2,
   parameter int DATA_W     = 8,
   parameter int BLINK_DIV  = 4,
   parameter bit LZ_BLANK   = 1'b0
) (
   input logic                clk,
   input logic                rst_n,
   seg_display_multi_if.slave bus
);
   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int IT_W  = $clog2(DATA_W + 1);
   localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [IT_W-1:0] LAST_IT = IT_W'(DATA_W - 1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

   localparam logic [8:0] G_DASH  = 9'b000000100;
   localparam logic [8:0] G_BLANK = 9'b000000000;
   localparam logic [8:0] G_F     = 9'b100011100;

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int k = 0; k < n; k++) p = p * 10;
      return p;
   endfunction

   localparam longint unsigned DEC_MAX = pow10(NUM_DIGITS) - 1;

   function automatic logic [8:0] hex_glyph(input logic [3:0] d);
      case (d)
         4'h0:    hex_glyph = 9'b111111000;
         4'h1:    hex_glyph = 9'b011000000;
         4'h2:    hex_glyph = 9'b110110100;
         4'h3:    hex_glyph = 9'b111100100;
         4'h4:    hex_glyph = 9'b011001100;
         4'h5:    hex_glyph = 9'b101101100;
         4'h6:    hex_glyph = 9'b101111100;
         4'h7:    hex_glyph = 9'b111000000;
         4'h8:    hex_glyph = 9'b111111100;
         4'h9:    hex_glyph = 9'b111101100;
         4'hA:    hex_glyph = 9'b111011100;
         4'hB:    hex_glyph = 9'b001111100;
         4'hC:    hex_glyph = 9'b100111000;
         4'hD:    hex_glyph = 9'b011110100;
         4'hE:    hex_glyph = 9'b100111100;
         default: hex_glyph = G_F;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   state_t                state;
   logic [BCD_W-1:0]      hex_q;
   logic                  mode_q;
   logic                  warn_cap;
   logic                  ovf_cap;
   logic [DATA_W-1:0]     shift_q;
   logic [BCD_W-1:0]      bcd_q;
   logic [IT_W-1:0]       it_q;
   logic [BCD_W-1:0]      digit_q;
   logic [NUM_DIGITS-1:0] blank_q;
   logic                  warn_q;
   logic                  ovf_q;
   logic                  update_q;
   logic [BL_W-1:0]       blink_cnt;
   logic                  phase_on;

   // Everything the result depends on is decided from the accept-edge inputs.
   logic             accept;
   logic [63:0]      value_ext;
   logic             in_warn;
   logic             in_ovf;
   logic [BCD_W-1:0] in_hex;

   assign accept    = bus.value_valid && (state == IDLE);
   assign value_ext = 64'(bus.value);
   assign in_warn   = (bus.value < bus.warn_lo) || (bus.value > bus.warn_hi);
   assign in_ovf    = bus.mode_dec ? (value_ext > DEC_MAX)
                                   : ((value_ext >> BCD_W) != 64'd0);

   if (DATA_W >= BCD_W) begin : g_hex_trunc
      assign in_hex = bus.value[BCD_W-1:0];
   end else begin : g_hex_ext
      assign in_hex = {{(BCD_W - DATA_W){1'b0}}, bus.value};
   end

   logic [BCD_W-1:0]      bcd_adj;
   logic [BCD_W-1:0]      bcd_next;
   logic [NUM_DIGITS-1:0] load_blank;
   logic                  seen_nz;

   // NOTE: every always_comb output gets a default before any conditional write, so no latch.
   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
   end

   assign bcd_next = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};

   // A digit is blank when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      load_blank = '0;
      seen_nz    = 1'b0;
      for (int d = NUM_DIGITS - 1; d > 0; d--) begin
         seen_nz       = seen_nz || (bcd_q[4*d +: 4] != 4'd0);
         load_blank[d] = mode_q && LZ_BLANK && !ovf_cap && !seen_nz;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the digit store is a handful of flops, so it is reset like any other state.
         state     <= IDLE;
         hex_q     <= '0;
         mode_q    <= 1'b0;
         warn_cap  <= 1'b0;
         ovf_cap   <= 1'b0;
         shift_q   <= '0;
         bcd_q     <= '0;
         it_q      <= '0;
         digit_q   <= '0;
         blank_q   <= '0;
         warn_q    <= 1'b0;
         ovf_q     <= 1'b0;
         update_q  <= 1'b0;
         blink_cnt <= '0;
         phase_on  <= 1'b1;
      end else begin
         update_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  hex_q    <= in_hex;
                  mode_q   <= bus.mode_dec;
                  warn_cap <= in_warn;
                  ovf_cap  <= in_ovf;
                  shift_q  <= bus.value;
                  bcd_q    <= '0;
                  it_q     <= '0;
                  state    <= bus.mode_dec ? CONV : LOAD;
               end
            end
            CONV: begin
               bcd_q   <= bcd_next;
               shift_q <= shift_q << 1;
               it_q    <= it_q + IT_W'(1);
               if (it_q == LAST_IT) state <= LOAD;
            end
            LOAD: begin
               digit_q  <= mode_q ? bcd_q : hex_q;
               blank_q  <= load_blank;
               warn_q   <= warn_cap;
               ovf_q    <= ovf_cap;
               update_q <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Any load restarts the blink on-phase; a steady display parks the counter.
         if (state == LOAD || !warn_q) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
         end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            phase_on  <= !phase_on;
         end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
         end
      end
   end

   logic [9*NUM_DIGITS-1:0] seg_c;

   always_comb begin
      seg_c = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (ovf_q)                seg_c[9*d +: 9] = G_DASH;
         else if (d == 0 && warn_q) seg_c[9*d +: 9] = phase_on ? G_F : G_BLANK;
         else if (blank_q[d])      seg_c[9*d +: 9] = G_BLANK;
         else                      seg_c[9*d +: 9] = hex_glyph(digit_q[4*d +: 4]);
      end
   end

   assign bus.seg      = seg_c;
   assign bus.ready    = (state == IDLE);
   assign bus.warn     = warn_q;
   assign bus.overflow = ovf_q;
   assign bus.update   = update_q;
endmodule

// File: tb/tb_seg_display_multi.sv
// Bench for seg_display_multi: directed scenarios plus random loads, checked by a
// scoreboard fed from a reference model of the display rules.
module tb_seg_display_multi;
   localparam int ND = 2;
   localparam int DW = 8;
   localparam int BD = 4;
   localparam bit LZ = 1'b1;
   localparam int SW = 9 * ND;

   localparam logic [8:0] GLYPH [16] = '{
      9'b111111000, 9'b011000000, 9'b110110100, 9'b111100100,
      9'b011001100, 9'b101101100, 9'b101111100, 9'b111000000,
      9'b111111100, 9'b111101100, 9'b111011100, 9'b001111100,
      9'b100111000, 9'b011110100, 9'b100111100, 9'b100011100
   };
   localparam logic [8:0] G_DASH  = 9'b000000100;
   localparam logic [8:0] G_BLANK = 9'b000000000;

   typedef struct {
      logic [SW-1:0] seg;
      logic          warn;
      logic          ovf;
      int            due;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg_display_multi_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();

   seg_display_multi #(
      .NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(BD), .LZ_BLANK(LZ)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_checks  = 0;
   int   n_fail    = 0;
   int   cyc       = 0;
   int   upd_count = 0;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint unsigned base_pow(input bit dec, input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * (dec ? 10 : 16);
      return p;
   endfunction

   function automatic bit model_ovf(input longint unsigned v, input bit dec);
      return v >= base_pow(dec, ND);
   endfunction

   function automatic bit model_warn(input longint unsigned v, input longint unsigned lo,
                                     input longint unsigned hi);
      return (v < lo) || (v > hi);
   endfunction

   // Display as seen by a reader: dashes on overflow, blinking F on warning, else digits.
   function automatic logic [SW-1:0] model_seg(input longint unsigned v, input bit dec,
                                               input longint unsigned lo,
                                               input longint unsigned hi, input bit on);
      logic [SW-1:0]   s;
      longint unsigned place;
      longint unsigned base;
      int              dig;
      s     = '0;
      base  = dec ? 10 : 16;
      place = 1;
      for (int i = 0; i < ND; i++) begin
         dig = int'((v / place) % base);
         if (model_ovf(v, dec))                    s[9*i +: 9] = G_DASH;
         else if (i == 0 && model_warn(v, lo, hi)) s[9*i +: 9] = on ? GLYPH[15] : G_BLANK;
         else if (dec && LZ && i > 0 && v < place) s[9*i +: 9] = G_BLANK;
         else                                      s[9*i +: 9] = GLYPH[dig];
         place = place * base;
      end
      return s;
   endfunction

   task automatic send(input logic [DW-1:0] v, input bit dec,
                       input logic [DW-1:0] lo, input logic [DW-1:0] hi);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge clk);
      while (bus.ready !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (bus.ready !== 1'b1) check("ready_wait", bus.ready, 1);
      bus.value       = v;
      bus.mode_dec    = dec;
      bus.warn_lo     = lo;
      bus.warn_hi     = hi;
      bus.value_valid = 1'b1;
      e.seg  = model_seg(v, dec, lo, hi, 1'b1);
      e.warn = model_warn(v, lo, hi);
      e.ovf  = model_ovf(v, dec);
      e.due  = cyc + (dec ? DW + 2 : 2);
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.value_valid = 1'b0;
      bus.value       = DW'($urandom);
      bus.mode_dec    = 1'($urandom);
      bus.warn_lo     = DW'($urandom);
      bus.warn_hi     = DW'($urandom);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("drain", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Monitor: every update pulse must match the oldest outstanding expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.update === 1'b1) begin
            upd_count++;
            if (sb.size() == 0) begin
               check("unexpected_update", bus.update, 0);
            end else begin
               e = sb.pop_front();
               check("sb_seg", bus.seg, e.seg);
               check("sb_warn", bus.warn, e.warn);
               check("sb_ovf", bus.overflow, e.ovf);
               check("sb_latency", cyc, e.due);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

   initial begin : stim
      int               u0;
      int               busy;
      int               guard;
      logic [DW-1:0]    v;
      logic [DW-1:0]    lo;
      logic [DW-1:0]    hi;

      bus.value_valid = 1'b0;
      bus.value       = '0;
      bus.mode_dec    = 1'b0;
      bus.warn_lo     = '0;
      bus.warn_hi     = '1;
      rst_n           = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", bus.ready, 1);
      check("rst_seg", bus.seg, {ND{GLYPH[0]}});
      check("rst_warn", bus.warn, 0);
      check("rst_ovf", bus.overflow, 0);
      check("rst_update", bus.update, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Hex load
      u0 = upd_count;
      send(8'h3A, 1'b0, 8'd0, 8'd255);
      wait_idle();
      check("hex_3A_seg", bus.seg, {9'b111100100, 9'b111011100});
      check("hex_3A_warn", bus.warn, 0);
      check("hex_single_update", upd_count - u0, 1);

      // Decimal load and busy window
      send(8'd59, 1'b1, 8'd0, 8'd255);
      busy  = 0;
      guard = 0;
      @(negedge clk);
      while (bus.ready !== 1'b1 && guard < 100) begin
         busy++;
         guard++;
         @(negedge clk);
      end
      check("dec_busy_cycles", busy, DW + 1);
      wait_idle();
      check("dec_59_seg", bus.seg, {GLYPH[5], GLYPH[9]});
      send(8'd7, 1'b1, 8'd0, 8'd255);
      wait_idle();
      check("dec_7_seg", bus.seg, {G_BLANK, GLYPH[7]});

      // Decimal overflow, then hex recovers
      send(8'd200, 1'b1, 8'd0, 8'd255);
      wait_idle();
      check("dec_ovf_flag", bus.overflow, 1);
      check("dec_ovf_seg", bus.seg, {G_DASH, G_DASH});
      send(8'hF5, 1'b0, 8'd0, 8'd255);
      wait_idle();
      check("hex_F5_ovf", bus.overflow, 0);
      check("hex_F5_seg", bus.seg, {GLYPH[15], GLYPH[5]});

      // Warning blink: on for BD cycles, off for BD, from the update cycle onward
      send(8'h25, 1'b0, 8'd1, 8'd3);
      guard = 0;
      while (bus.update !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("blink_update_seen", bus.update, 1);
      for (int k = 0; k < 4 * BD; k++) begin
         check("blink_d0", bus.seg[8:0], ((k / BD) % 2 == 0) ? GLYPH[15] : G_BLANK);
         check("blink_d1", bus.seg[17:9], GLYPH[2]);
         check("blink_warn", bus.warn, 1);
         @(negedge clk);
      end
      send(8'h02, 1'b0, 8'd1, 8'd3);
      wait_idle();
      for (int k = 0; k < 2 * BD + 2; k++) begin
         check("steady_d0", bus.seg[8:0], GLYPH[2]);
         check("steady_warn", bus.warn, 0);
         @(negedge clk);
      end

      // Requests while busy are dropped
      send(8'd59, 1'b1, 8'd0, 8'd255);
      repeat (2) @(negedge clk);
      bus.value       = 8'h11;
      bus.mode_dec    = 1'b0;
      bus.value_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.value_valid = 1'b0;
      wait_idle();
      check("busy_ignore_seg", bus.seg, {GLYPH[5], GLYPH[9]});

      // Inverted bounds: everything warns
      for (int i = 0; i < 4; i++) begin
         send(DW'($urandom), 1'($urandom), 8'd10, 8'd5);
         wait_idle();
         check("lo_gt_hi_warn", bus.warn, 1);
      end

      // Random back-to-back traffic
      for (int i = 0; i < 60; i++) begin
         v  = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 12)) : DW'($urandom);
         lo = DW'($urandom_range(0, 60));
         hi = DW'($urandom_range(0, 255));
         send(v, 1'($urandom), lo, hi);
      end
      wait_idle();

      // Reset in the middle of a conversion
      send(8'd42, 1'b1, 8'd0, 8'd255);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("midrst_ready", bus.ready, 1);
      check("midrst_seg", bus.seg, {ND{GLYPH[0]}});
      check("midrst_warn", bus.warn, 0);
      check("midrst_ovf", bus.overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      u0    = upd_count;
      repeat (30) @(negedge clk);
      check("midrst_no_update", upd_count - u0, 0);
      check("midrst_seg_after", bus.seg, {ND{GLYPH[0]}});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
